// File: rtl/gemm_seq.sv
// Sequential GEMM engine: streams operand pairs from the two source buffers,
// accumulates K products per output and writes N_OUT results to the destination buffer.
module gemm_seq #(
  parameter int K     = 2,
  parameter int N_OUT = 16,
  parameter int AW    = 5,
  parameter int OW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          exec,
  output logic [AW-1:0] ia,
  input  logic [31:0]   a_d,
  input  logic [31:0]   b_d,
  output logic          outr,
  output logic [OW-1:0] oa,
  output logic [31:0]   result
);

  localparam int T  = N_OUT * K;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          exec_q, exec_d;
  logic [AW-1:0] ia_q, ia_d;
  logic [KW-1:0] ik_q, ik_d;
  logic [OW-1:0] io_q, io_d;
  logic          vld_q, vld_d;
  logic [KW-1:0] dk_q, dk_d;
  logic [OW-1:0] do_q, do_d;
  logic [31:0]   acc_q, acc_d;
  logic          outr_q, outr_d;
  logic [OW-1:0] oa_q, oa_d;
  logic [31:0]   result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      exec_q   <= 1'b0;
      ia_q     <= '0;
      ik_q     <= '0;
      io_q     <= '0;
      vld_q    <= 1'b0;
      dk_q     <= '0;
      do_q     <= '0;
      acc_q    <= '0;
      outr_q   <= 1'b0;
      oa_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exec_q   <= exec_d;
      ia_q     <= ia_d;
      ik_q     <= ik_d;
      io_q     <= io_d;
      vld_q    <= vld_d;
      dk_q     <= dk_d;
      do_q     <= do_d;
      acc_q    <= acc_d;
      outr_q   <= outr_d;
      oa_q     <= oa_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    exec_d   = 1'b0;
    ia_d     = ia_q;
    ik_d     = ik_q;
    io_d     = io_q;
    acc_d    = acc_q;
    outr_d   = 1'b0;
    oa_d     = oa_q;
    result_d = result_q;
    // Tags travel with the read so they line up with the returning operand pair.
    vld_d    = exec_q;
    dk_d     = ik_q;
    do_d     = io_q;
    prod     = a_d * b_d;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          exec_d  = 1'b1;
          ia_d    = '0;
          ik_d    = '0;
          io_d    = '0;
        end
      end
      S_RUN: begin
        if (ia_q == AW'(T - 1)) begin
          state_d = S_DRAIN1;
        end else begin
          exec_d = 1'b1;
          ia_d   = ia_q + AW'(1);
          if (ik_q == KW'(K - 1)) begin
            ik_d = '0;
            io_d = io_q + OW'(1);
          end else begin
            ik_d = ik_q + KW'(1);
          end
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (vld_q) begin
      acc_d = (dk_q == '0) ? prod : acc_q + prod;
      if (dk_q == KW'(K - 1)) begin
        outr_d   = 1'b1;
        result_d = acc_d;
        oa_d     = do_q;
      end
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign exec   = exec_q;
  assign ia     = ia_q;
  assign outr   = outr_q;
  assign oa     = oa_q;
  assign result = result_q;

endmodule

// File: tb/tb_gemm_seq.sv
// Scoreboard bench for gemm_seq: a default (K=2) instance and a K=1 instance
// share synchronous source-buffer models; expected writes are queued per run.
module tb_gemm_seq;

  typedef struct {
    logic [3:0]  oa;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, exec0, outr0, busy1, done1, exec1, outr1;
  logic [4:0] ia0, ia1;
  logic [3:0] oa0, oa1;
  logic [31:0] result0, result1, ad0, bd0, ad1, bd1;
  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];

  int sel = 0;
  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

  logic        busy_m, done_m, exec_m, outr_m;
  logic [4:0]  ia_m;
  logic [3:0]  oa_m;
  logic [31:0] result_m;

  gemm_seq #(.K(2), .N_OUT(16), .AW(5), .OW(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .exec(exec0), .ia(ia0), .a_d(ad0), .b_d(bd0),
    .outr(outr0), .oa(oa0), .result(result0)
  );

  gemm_seq #(.K(1), .N_OUT(16), .AW(5), .OW(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .exec(exec1), .ia(ia1), .a_d(ad1), .b_d(bd1),
    .outr(outr1), .oa(oa1), .result(result1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (exec0) begin ad0 <= mem_a[ia0]; bd0 <= mem_b[ia0]; end
    if (exec1) begin ad1 <= mem_a[ia1]; bd1 <= mem_b[ia1]; end
  end

  always_comb begin
    busy_m   = (sel == 1) ? busy1   : busy0;
    done_m   = (sel == 1) ? done1   : done0;
    exec_m   = (sel == 1) ? exec1   : exec0;
    outr_m   = (sel == 1) ? outr1   : outr0;
    ia_m     = (sel == 1) ? ia1     : ia0;
    oa_m     = (sel == 1) ? oa1     : oa0;
    result_m = (sel == 1) ? result1 : result0;
  end

  // Every destination write is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (outr_m === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_outr: oa=%0d result=%h cycle=%0d, required no write",
                 oa_m, result_m, cyc - base + 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (oa_m !== e.oa || result_m !== e.res || (cyc - base + 1) != e.cyc) begin
          errors++;
          $display("FAIL write: oa=%0d result=%h cycle=%0d, required oa=%0d result=%h cycle=%0d",
                   oa_m, result_m, cyc - base + 1, e.oa, e.res, e.cyc);
        end
      end
    end
  end

  function automatic void push_expected(input int kk);
    for (int o = 0; o < 16; o++) begin
      exp_t e;
      logic [31:0] acc, p;
      acc = 32'd0;
      for (int k = 0; k < kk; k++) begin
        p   = mem_a[o*kk + k] * mem_b[o*kk + k];
        acc = acc + p;
      end
      e.oa  = 4'(o);
      e.res = acc;
      e.cyc = o*kk + kk + 2;
      q.push_back(e);
    end
  endfunction

  task automatic run(input int s, input bit hold);
    int kk, t, busy_n, exec_n, done_n, done_at, n;
    kk = (s == 1) ? 1 : 2;
    t  = 16 * kk;
    busy_n = 0; exec_n = 0; done_n = 0; done_at = -1;
    push_expected(kk);
    sel = s;
    @(negedge clk);
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    base = cyc;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    for (int i = 1; i <= t + 8; i++) begin
      @(negedge clk);
      n = cyc - base + 1;
      if (busy_m === 1'b1) busy_n++;
      if (exec_m === 1'b1) begin
        checks++;
        if (ia_m !== 5'(exec_n) || n != exec_n + 1) begin
          errors++;
          $display("FAIL issue: ia=%0d cycle=%0d, required ia=%0d cycle=%0d", ia_m, n, exec_n, exec_n + 1);
        end
        exec_n++;
      end
      if (done_m === 1'b1) begin done_n++; done_at = n; end
      if (i == t + 4) begin start0 = 1'b0; start1 = 1'b0; end
    end
    checks++;
    if (busy_n != t + 3) begin
      errors++;
      $display("FAIL busy_len: got %0d, required %0d", busy_n, t + 3);
    end
    checks++;
    if (done_n != 1 || done_at != t + 3) begin
      errors++;
      $display("FAIL done: pulses=%0d at=%0d, required 1 at %0d", done_n, done_at, t + 3);
    end
    checks++;
    if (exec_n != t) begin
      errors++;
      $display("FAIL exec_count: got %0d, required %0d", exec_n, t);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy0, done0, exec0, outr0, busy1, done1, exec1, outr1} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {busy0, done0, exec0, outr0, busy1, done1, exec1, outr1});
    end
    checks++;
    if (ia0 !== 5'd0 || oa0 !== 4'd0 || result0 !== 32'd0 || ia1 !== 5'd0 || oa1 !== 4'd0 || result1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: ia=%0d/%0d oa=%0d/%0d result=%h/%h, required all 0",
               ia0, ia1, oa0, oa1, result0, result1);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_accumulate();
    for (int i = 0; i < 32; i++) begin mem_a[i] = 32'(i + 1); mem_b[i] = 32'd1; end
    run(0, 1'b0);
  endtask

  task automatic test_signed();
    for (int i = 0; i < 32; i++) begin mem_a[i] = 32'(i * 7); mem_b[i] = 32'(i + 3); end
    mem_a[0] = -32'sd3; mem_b[0] = 32'd5;
    mem_a[1] = 32'd7;   mem_b[1] = 32'd2;
    mem_a[2] = 32'hFFFFFFFF; mem_b[2] = 32'hFFFFFFFF;
    mem_a[3] = 32'hFFFFFFFF; mem_b[3] = 32'hFFFFFFFF;
    run(0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 32; i++) begin mem_a[i] = 32'h80000000; mem_b[i] = 32'd2; end
    run(0, 1'b0);
  endtask

  task automatic test_start_held();
    for (int i = 0; i < 32; i++) begin mem_a[i] = 32'(i * i); mem_b[i] = 32'(31 - i); end
    run(0, 1'b1);
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 32; i++) begin mem_a[i] = 32'(3 * i + 1); mem_b[i] = 32'(i + 2); end
    push_expected(2);
    sel = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    base = cyc;
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({exec0, outr0, busy0, done0} !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset: exec,outr,busy,done=%b, required 0000", {exec0, outr0, busy0, done0});
    end
    checks++;
    if (ia0 !== 5'd0 || oa0 !== 4'd0 || result0 !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset_data: ia=%0d oa=%0d result=%h, required 0", ia0, oa0, result0);
    end
    q.delete();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || exec0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b exec=%b, required 0 0", busy0, exec0);
    end
    run(0, 1'b0);
  endtask

  task automatic test_k1();
    for (int i = 0; i < 32; i++) begin mem_a[i] = 32'(i); mem_b[i] = 32'd3; end
    run(1, 1'b0);
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_signed();
    test_overflow();
    test_start_held();
    test_reset_midrun();
    test_k1();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
